shift_arbiter: RTL
==================

// Module: shift_arbiter
// PURPOSE
//   Shares one barrel_shifter instance between NREQ requesters using round-robin arbitration.
//   Each requester presents an operand, a shift amount and a selector on a valid/ready port.
//   The block grants one requester, registers its operands, drives the shared shifter and returns
//   the registered result tagged with the requester ID.
//   Sits between the issue logic and the shift datapath.
// PARAMETERS
//   NREQ  4  number of requesters (2..8)
//   IDW   2  response ID width, IDW = clog2(NREQ)
// PORTS
//   clk        in   1         rising-edge clock
//   rst_n      in   1         asynchronous active-low reset
//   req_valid  in   NREQ      per-requester valid
//   req_ready  out  NREQ      per-requester accept, one-hot or zero
//   req_data   in   32*NREQ   operand; slot i = [32*i+31:32*i]
//   req_shift  in   6*NREQ    shift amount; slot i = [6*i+5:6*i]
//   req_sel    in   2*NREQ    00 SLL, 01 SRL, 10 SRA, 11 pass-through
//   rsp_valid  out  1         result valid
//   rsp_ready  in   1         downstream accept
//   rsp_data   out  32        shifted result
//   rsp_id     out  IDW       index of the requester that owns rsp_data
//   rsp_err    out  1         only when SHIFT_ERR_EN is defined
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0,
//   rsp_err=0. Operand registers are cleared to 0.
//   Arbitration (combinational):
//     - grant = first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo NREQ.
//     - req_ready[i] = (state==IDLE) & grant[i]. An accept is req_valid[i] & req_ready[i].
//   FSM:
//     - IDLE: on accept, capture data/shift/sel/id into op_* registers, set rr_ptr=(i+1)%NREQ,
//       go to EXEC. With no valid request, stay in IDLE.
//     - EXEC: the shifter output from op_* is registered into rsp_data/rsp_id, rsp_valid<=1,
//       go to RESP.
//     - RESP: hold rsp_* stable while rsp_ready=0. On rsp_valid & rsp_ready, rsp_valid<=0 and go
//       to IDLE.
//   Latency: accept in cycle N gives rsp_valid=1 in cycle N+2. Throughput is at most one operation
//   every 3 cycles.
//   Shifter semantics:
//     - sel 00 is a logical left shift; 01 is a logical right shift; 10 is an arithmetic right
//       shift (sign-fill from bit 31).
//     - shift=32 gives 0 for SLL/SRL and {32{in[31]}} for SRA.
//     - shift>32 or sel=11 passes the operand through unchanged.
//   Boundaries:
//     - req_valid drop while not granted: legal, no effect.
//     - All NREQ requesters valid continuously: each is granted exactly once per NREQ accepts.
//     - rr_ptr advances only on accept, never on idle cycles.
//     - Requester inputs are ignored outside IDLE. req_ready stays 0 in EXEC and RESP.
//     - rsp_ready held high: response completes in the RESP entry cycle. The next accept happens
//       the following cycle at the earliest.
//     - Reset mid-operation: the operation is dropped. No response is issued after reset.
// CONFIGURATION
//   SHIFT_ERR_EN defined:
//     - Adds the rsp_err port.
//     - rsp_err is registered with rsp_data and is 1 when op_shift>32 or op_sel==2'b11.
//     - rsp_data still carries the pass-through operand.
//   SHIFT_ERR_EN undefined:
//     - The rsp_err port and its register do not exist.
//     - Those cases are silent pass-throughs.
// TESTING
//   T1:
//     - Stimulus: reset, then req0 data=32'h0000_00F0, shift=4, sel=00; rsp_ready=1.
//     - Response: rsp_data=32'h0000_0F00, rsp_id=0, rsp_valid 2 cycles after accept.
//   T2:
//     - Stimulus: req1 data=32'h8000_0000, shift=31, sel=10.
//     - Response: rsp_data=32'hFFFF_FFFF.
//     - Then: same operand with sel=01 gives 32'h0000_0001; shift=32 with sel=01 gives 0.
//   T3:
//     - Stimulus: all 4 requesters valid continuously, rsp_ready=1.
//     - Response: rsp_id sequence 0,1,2,3,0,1,...
//     - Each req_ready pulse lasts 1 cycle, 3 cycles apart.
//   T4:
//     - Stimulus: hold rsp_ready=0 for 5 cycles in RESP with req2 valid.
//     - Response: rsp_data/rsp_id stay stable and req_ready=0 throughout.
//     - Then: rsp_ready=1 completes the response and grants req2 on the next cycle.
//   T5:
//     - Stimulus: shift=40, sel=00, data=32'h1234_5678.
//     - Response: rsp_data=32'h1234_5678; rsp_err=1 with SHIFT_ERR_EN (port absent without it).
//     - Then: sel=11 with shift=3 behaves the same.
//   T6:
//     - Stimulus: assert rst_n=0 during EXEC.
//     - Response: rsp_valid=0 and req_ready=0 immediately.
//     - After release: no stale response appears; the next grant starts from requester 0.

Source files
------------

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin arbiter that shares one barrel shifter between NREQ requesters.
// Define SHIFT_ERR_EN to add rsp_err, which flags out-of-range shift amounts and the pass-through selector.
module shift_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_data,
  input  logic [6*NREQ-1:0]    req_shift,
  input  logic [2*NREQ-1:0]    req_sel,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [IDW-1:0]       rsp_id
`ifdef SHIFT_ERR_EN
  ,
  output logic                 rsp_err
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         r_state;
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] r_op_id;
  logic [31:0]    r_op_data;
  logic [5:0]     r_op_shift;
  logic [1:0]     r_op_sel;

  logic           w_gnt_found;
  logic [IDW-1:0] w_gnt_idx;
  logic [IDW-1:0] w_idx;
  logic [IDW-1:0] w_next_ptr;
  logic           w_accept;
  logic [31:0]    w_shift_res;
  logic           w_shift_err;

  function automatic logic [31:0] barrel(input logic [31:0] d, input logic [5:0] sh,
                                         input logic [1:0] sel);
    logic [31:0] res;
    res = d;
    if (sh <= 6'd32) begin
      case (sel)
        2'b00: if (sh == 6'd32) res = 32'd0; else res = d << sh[4:0];
        2'b01: if (sh == 6'd32) res = 32'd0; else res = d >> sh[4:0];
        2'b10: if (sh == 6'd32) res = {32{d[31]}}; else res = $signed(d) >>> sh[4:0];
        default: res = d;
      endcase
    end
    return res;
  endfunction

  // Search from the round-robin pointer upward, wrapping modulo NREQ.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = IDW'((int'(r_rr_ptr) + k) % NREQ);
      if (!w_gnt_found && req_valid[w_idx]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_idx;
      end
    end
  end

  // Gated by rst_n so no accept is offered while reset is held.
  assign req_ready   = (r_state == IDLE && w_gnt_found && rst_n) ? (NREQ'(1) << w_gnt_idx) : '0;
  assign w_accept    = |(req_valid & req_ready);
  assign w_next_ptr  = IDW'((int'(w_gnt_idx) + 1) % NREQ);
  assign w_shift_res = barrel(r_op_data, r_op_shift, r_op_sel);
  assign w_shift_err = (r_op_shift > 6'd32) || (r_op_sel == 2'b11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_op_id    <= '0;
      r_op_data  <= '0;
      r_op_shift <= '0;
      r_op_sel   <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= '0;
`ifdef SHIFT_ERR_EN
      rsp_err    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op_data  <= req_data[32*w_gnt_idx +: 32];
            r_op_shift <= req_shift[6*w_gnt_idx +: 6];
            r_op_sel   <= req_sel[2*w_gnt_idx +: 2];
            r_op_id    <= w_gnt_idx;
            r_rr_ptr   <= w_next_ptr;
            r_state    <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= w_shift_res;
          rsp_id    <= r_op_id;
`ifdef SHIFT_ERR_EN
          rsp_err   <= w_shift_err;
`endif
          rsp_valid <= 1'b1;
          r_state   <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifndef SHIFT_ERR_EN
  logic w_unused;
  assign w_unused = w_shift_err;
`endif

endmodule
